// File: rtl/aos_strm_pkg.sv
// rtl/aos_strm_pkg.sv - stream buffer address map, depth and read-scheduler state type
package aos_strm_pkg;

    localparam logic [63:0] STRM_R_STAT    = 64'd0;
    localparam logic [63:0] STRM_W_STAT    = 64'd64;
    localparam logic [63:0] STRM_FR_STAT   = 64'd128;
    localparam logic [63:0] STRM_FW_STAT   = 64'd192;
    localparam logic [63:0] STRM_DATA_ADDR = 64'd256;

    localparam int STRM_DATA_FIFO_LD = 14;

    typedef enum logic [2:0] {
        IDLE,
        POLL_AR,
        POLL_R,
        WAIT,
        DATA_AR,
        DATA_R
    } strm_rd_state_t;

    // Beats in the next data burst: whatever credit is available, capped at the burst limit
    function automatic int burst_beats(input int avail, input int max_burst);
        return (avail > max_burst) ? max_burst : avail;
    endfunction

endpackage

// File: rtl/strm_rd_sched.sv
// rtl/strm_rd_sched.sv - stream buffer read scheduler (credit poll + bursts), optional STRM_RD_SCHED_STATS_EN counters
module strm_rd_sched
    import aos_strm_pkg::*;
#(
    parameter int          DATA_FIFO_LD = STRM_DATA_FIFO_LD,
    parameter int          MAX_BURST    = 64,
    parameter int          POLL_GAP     = 16,
    parameter logic [15:0] ARID         = 16'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [63:0]           araddr,
    output logic [7:0]            arlen,
    output logic [15:0]           arid,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [511:0]          rdata,
    input  logic                  ruser,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [511:0]          out_data,
    output logic                  out_user,
    output logic                  out_last,
    output logic                  err,
    output logic [DATA_FIFO_LD:0] credits
`ifdef STRM_RD_SCHED_STATS_EN
    ,
    output logic [31:0]           stat_beats,
    output logic [31:0]           stat_polls
`endif
);

    localparam int CW = DATA_FIFO_LD + 1;
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [CW:0] CRED_MAX = (CW + 1)'(1) << DATA_FIFO_LD;

    strm_rd_state_t state;
    logic [GW-1:0]  gap_cnt;
    logic [CW:0]    poll_sum;
    logic [CW-1:0]  poll_total;
    logic [7:0]     len_from_credits;
    logic [7:0]     len_from_poll;
    logic           r_hs;
    logic           out_hs;

    assign arid      = ARID;
    assign rready    = (state == POLL_R) || ((state == DATA_R) && out_ready);
    assign out_valid = (state == DATA_R) && rvalid;
    assign out_data  = rdata;
    assign out_user  = ruser;
    assign out_last  = rlast;
    assign r_hs      = rvalid && rready;
    assign out_hs    = out_valid && out_ready;

    // New credit total after folding in a poll beat, clipped at the buffer depth
    always_comb begin
        poll_sum   = {1'b0, credits} + {1'b0, rdata[DATA_FIFO_LD:0]};
        poll_total = (poll_sum > CRED_MAX) ? CRED_MAX[CW-1:0] : poll_sum[CW-1:0];
    end

    // Burst length for a data AR launched from the held count or straight from a poll result
    always_comb begin
        len_from_credits = 8'(burst_beats(int'(credits), MAX_BURST) - 1);
        len_from_poll    = 8'(burst_beats(int'(poll_total), MAX_BURST) - 1);
    end

    // Scheduler FSM: one outstanding AR at a time, AR fields registered and held until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            credits <= '0;
            gap_cnt <= '0;
            err     <= 1'b0;
            arvalid <= 1'b0;
            araddr  <= '0;
            arlen   <= '0;
        end else begin
            if (r_hs && (rresp != 2'b00)) begin
                err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (enable) begin
                        arvalid <= 1'b1;
                        if (credits == '0) begin
                            state  <= POLL_AR;
                            araddr <= STRM_R_STAT;
                            arlen  <= 8'd0;
                        end else begin
                            state  <= DATA_AR;
                            araddr <= STRM_DATA_ADDR;
                            arlen  <= len_from_credits;
                        end
                    end
                end
                POLL_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        state   <= POLL_R;
                    end
                end
                POLL_R: begin
                    if (rvalid) begin
                        credits <= poll_total;
                        if (!enable) begin
                            state <= IDLE;
                        end else if (poll_total == '0) begin
                            state   <= WAIT;
                            gap_cnt <= '0;
                        end else begin
                            state   <= DATA_AR;
                            arvalid <= 1'b1;
                            araddr  <= STRM_DATA_ADDR;
                            arlen   <= len_from_poll;
                        end
                    end
                end
                WAIT: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (gap_cnt == GW'(POLL_GAP - 1)) begin
                        state   <= POLL_AR;
                        arvalid <= 1'b1;
                        araddr  <= STRM_R_STAT;
                        arlen   <= 8'd0;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                DATA_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        credits <= credits - CW'({1'b0, arlen} + 9'd1);
                        state   <= DATA_R;
                    end
                end
                DATA_R: begin
                    if (out_hs && rlast) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef STRM_RD_SCHED_STATS_EN
    // Forwarded-beat and poll-request counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_beats <= 32'd0;
            stat_polls <= 32'd0;
        end else begin
            if (out_hs) begin
                stat_beats <= stat_beats + 32'd1;
            end
            if ((state == POLL_AR) && arready) begin
                stat_polls <= stat_polls + 32'd1;
            end
        end
    end
`endif

endmodule
